// File: rtl/memory_stage.sv
`timescale 1ns/1ps
// Memory stage: data-memory load/store sequencing, load extraction and
// writeback register for the in-order pipeline.
module memory_stage (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [63:0] MEM_NPC,
    input  logic [63:0] MEM_ALU_RESULT,
    input  logic [63:0] MEM_SR2,
    input  logic [63:0] MEM_CSRFD,
    input  logic [63:0] MEM_RFD,
    input  logic        MEM_ECALL,
    output logic        V_MEM_STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic [7:0]  DMEM_WSTRB,
    input  logic [63:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        WB_V,
    output logic [31:0] WB_IR,
    output logic [63:0] WB_NPC,
    output logic [63:0] WB_RESULT,
    output logic [63:0] WB_CSRFD,
    output logic [63:0] WB_RFD,
    output logic        WB_ECALL,
    output logic        WB_MISALIGN
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  size;
    logic [2:0]  off;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        is_sys;
    logic        misaligned;
    logic        mem_op;
    logic        acc;
    logic        mis_exc;
    logic        req;
    logic        stall;
    logic [7:0]  strb;
    logic [63:0] wrep;
    logic [63:0] shifted;
    logic [63:0] ld_data;
    logic [63:0] result;

    logic        wb_v_q, wb_v_d;
    logic [31:0] wb_ir_q, wb_ir_d;
    logic [63:0] wb_npc_q, wb_npc_d;
    logic [63:0] wb_result_q, wb_result_d;
    logic [63:0] wb_csrfd_q, wb_csrfd_d;
    logic [63:0] wb_rfd_q, wb_rfd_d;
    logic        wb_ecall_q, wb_ecall_d;
    logic        wb_misalign_q, wb_misalign_d;

    always_comb begin
        opcode   = MEM_IR[6:0];
        funct3   = MEM_IR[14:12];
        size     = funct3[1:0];
        off      = MEM_ALU_RESULT[2:0];
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
        is_sys   = (opcode == OP_SYSTEM);
        misaligned = 1'b0;
        case (size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = off[0];
            2'd2: misaligned = |off[1:0];
            2'd3: misaligned = |off;
            default: misaligned = 1'b0;
        endcase
        mem_op  = is_load | is_store;
        acc     = MEM_V & mem_op & ~misaligned;
        mis_exc = MEM_V & mem_op & misaligned;
    end

    // ACK is only meaningful once a request has been held into WAIT
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d = S_WAIT;
                    req     = 1'b1;
                    stall   = 1'b1;
                end
            end
            S_WAIT: begin
                req   = 1'b1;
                stall = ~DMEM_ACK;
                if (DMEM_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        strb = 8'h00;
        wrep = MEM_SR2;
        case (size)
            2'd0: begin
                strb = 8'h01 << off;
                wrep = {8{MEM_SR2[7:0]}};
            end
            2'd1: begin
                strb = 8'h03 << off;
                wrep = {4{MEM_SR2[15:0]}};
            end
            2'd2: begin
                strb = 8'h0F << off;
                wrep = {2{MEM_SR2[31:0]}};
            end
            2'd3: begin
                strb = 8'hFF;
                wrep = MEM_SR2;
            end
            default: begin
                strb = 8'h00;
                wrep = MEM_SR2;
            end
        endcase
    end

    always_comb begin
        shifted = DMEM_RDATA >> {off, 3'b000};
        ld_data = shifted;
        case (funct3)
            3'd0: ld_data = {{56{shifted[7]}}, shifted[7:0]};
            3'd1: ld_data = {{48{shifted[15]}}, shifted[15:0]};
            3'd2: ld_data = {{32{shifted[31]}}, shifted[31:0]};
            3'd4: ld_data = {56'd0, shifted[7:0]};
            3'd5: ld_data = {48'd0, shifted[15:0]};
            3'd6: ld_data = {32'd0, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    // Misaligned memory ops fall through to the address as their result
    always_comb begin
        result = MEM_ALU_RESULT;
        unique case (1'b1)
            is_load & ~misaligned: result = ld_data;
            is_jump:               result = MEM_NPC;
            is_sys:                result = MEM_CSRFD;
            default:               result = MEM_ALU_RESULT;
        endcase
    end

    always_comb begin
        wb_v_d        = 1'b0;
        wb_ir_d       = wb_ir_q;
        wb_npc_d      = wb_npc_q;
        wb_result_d   = wb_result_q;
        wb_csrfd_d    = wb_csrfd_q;
        wb_rfd_d      = wb_rfd_q;
        wb_ecall_d    = wb_ecall_q;
        wb_misalign_d = wb_misalign_q;
        if (!stall) begin
            wb_v_d        = MEM_V;
            wb_ir_d       = MEM_IR;
            wb_npc_d      = MEM_NPC;
            wb_result_d   = result;
            wb_csrfd_d    = MEM_CSRFD;
            wb_rfd_d      = MEM_RFD;
            wb_ecall_d    = MEM_ECALL;
            wb_misalign_d = mis_exc;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            wb_v_q        <= 1'b0;
            wb_ir_q       <= 32'd0;
            wb_npc_q      <= 64'd0;
            wb_result_q   <= 64'd0;
            wb_csrfd_q    <= 64'd0;
            wb_rfd_q      <= 64'd0;
            wb_ecall_q    <= 1'b0;
            wb_misalign_q <= 1'b0;
        end else begin
            wb_v_q        <= wb_v_d;
            wb_ir_q       <= wb_ir_d;
            wb_npc_q      <= wb_npc_d;
            wb_result_q   <= wb_result_d;
            wb_csrfd_q    <= wb_csrfd_d;
            wb_rfd_q      <= wb_rfd_d;
            wb_ecall_q    <= wb_ecall_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign V_MEM_STALL = stall;
    assign DMEM_REQ    = req;
    assign DMEM_WE     = req & is_store;
    assign DMEM_ADDR   = {MEM_ALU_RESULT[63:3], 3'b000};
    assign DMEM_WSTRB  = is_store ? strb : 8'h00;
    assign DMEM_WDATA  = is_store ? wrep : 64'd0;

    assign WB_V        = wb_v_q;
    assign WB_IR       = wb_ir_q;
    assign WB_NPC      = wb_npc_q;
    assign WB_RESULT   = wb_result_q;
    assign WB_CSRFD    = wb_csrfd_q;
    assign WB_RFD      = wb_rfd_q;
    assign WB_ECALL    = wb_ecall_q;
    assign WB_MISALIGN = wb_misalign_q;

endmodule

// File: tb/tb_memory_stage.sv
`timescale 1ns/1ps
// Directed and randomized checks of memory_stage against an
// instruction-level model of loads, stores and writeback.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        RESET;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [63:0] MEM_NPC;
    logic [63:0] MEM_ALU_RESULT;
    logic [63:0] MEM_SR2;
    logic [63:0] MEM_CSRFD;
    logic [63:0] MEM_RFD;
    logic        MEM_ECALL;
    logic        V_MEM_STALL;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [63:0] DMEM_ADDR;
    logic [63:0] DMEM_WDATA;
    logic [7:0]  DMEM_WSTRB;
    logic [63:0] DMEM_RDATA;
    logic        DMEM_ACK;
    logic        WB_V;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC;
    logic [63:0] WB_RESULT;
    logic [63:0] WB_CSRFD;
    logic [63:0] WB_RFD;
    logic        WB_ECALL;
    logic        WB_MISALIGN;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk),
        .RESET(RESET),
        .MEM_V(MEM_V),
        .MEM_IR(MEM_IR),
        .MEM_NPC(MEM_NPC),
        .MEM_ALU_RESULT(MEM_ALU_RESULT),
        .MEM_SR2(MEM_SR2),
        .MEM_CSRFD(MEM_CSRFD),
        .MEM_RFD(MEM_RFD),
        .MEM_ECALL(MEM_ECALL),
        .V_MEM_STALL(V_MEM_STALL),
        .DMEM_REQ(DMEM_REQ),
        .DMEM_WE(DMEM_WE),
        .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA),
        .DMEM_WSTRB(DMEM_WSTRB),
        .DMEM_RDATA(DMEM_RDATA),
        .DMEM_ACK(DMEM_ACK),
        .WB_V(WB_V),
        .WB_IR(WB_IR),
        .WB_NPC(WB_NPC),
        .WB_RESULT(WB_RESULT),
        .WB_CSRFD(WB_CSRFD),
        .WB_RFD(WB_RFD),
        .WB_ECALL(WB_ECALL),
        .WB_MISALIGN(WB_MISALIGN)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Byte lanes touched by an n-byte access starting at byte off
    function automatic logic [7:0] strobe_of(int off, int n);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [63:0] wdata_of(logic [63:0] sr2, int n);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = sr2[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] load_of(logic [63:0] rd, int f3, int off);
        logic [63:0] v;
        int n;
        n = 1 << (f3 % 4);
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*((off + i) % 8) +: 8];
        if (f3 <= 2 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic run(input logic v, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] sr2, input logic [63:0] npc,
                       input logic [63:0] rdata, input int lat);
        logic [31:0] ir;
        logic [63:0] csrfd, rfd, exp_res;
        logic ecall, ld, st, mis, acc, exc;
        int n, off, stalls;
        ir = $urandom;
        ir[6:0] = opc;
        ir[14:12] = f3;
        csrfd = rnd64();
        rfd = rnd64();
        ecall = 1'($urandom % 2);
        ld = (opc == 7'h03);
        st = (opc == 7'h23);
        n = 1 << f3[1:0];
        off = int'(addr % 8);
        mis = (off % n) != 0;
        acc = v && (ld || st) && !mis;
        exc = v && (ld || st) && mis;
        if (exc) exp_res = addr;
        else if (ld) exp_res = load_of(rdata, int'(f3), off);
        else if (opc == 7'h6F || opc == 7'h67) exp_res = npc;
        else if (opc == 7'h73) exp_res = csrfd;
        else exp_res = addr;

        @(negedge clk);
        MEM_V = v;
        MEM_IR = ir;
        MEM_NPC = npc;
        MEM_ALU_RESULT = addr;
        MEM_SR2 = sr2;
        MEM_CSRFD = csrfd;
        MEM_RFD = rfd;
        MEM_ECALL = ecall;
        DMEM_ACK = 1'($urandom % 2);
        DMEM_RDATA = rnd64();
        #1;
        chk("req", 64'(DMEM_REQ), 64'(acc));
        chk("stall", 64'(V_MEM_STALL), 64'(acc));
        chk("we", 64'(DMEM_WE), 64'(acc && st));
        if (acc) chk("addr", DMEM_ADDR, addr - 64'(off));
        if (acc && st) begin
            chk("wstrb", 64'(DMEM_WSTRB), 64'(strobe_of(off, n)));
            chk("wdata", DMEM_WDATA, wdata_of(sr2, n));
        end
        if (acc) begin
            stalls = 1;
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk);
                #1;
                chk("bubble", 64'(WB_V), 64'd0);
                @(negedge clk);
                DMEM_ACK = (k == lat);
                DMEM_RDATA = (k == lat) ? rdata : rnd64();
                #1;
                chk("req_wait", 64'(DMEM_REQ), 64'd1);
                if (V_MEM_STALL) stalls++;
            end
            chk("stall_cycles", 64'(stalls), 64'(lat));
        end
        @(posedge clk);
        #1;
        DMEM_ACK = 1'b0;
        chk("wb_v", 64'(WB_V), 64'(v));
        chk("wb_ir", 64'(WB_IR), 64'(ir));
        chk("wb_misalign", 64'(WB_MISALIGN), 64'(exc));
        if (v) begin
            chk("wb_result", WB_RESULT, exp_res);
            chk("wb_npc", WB_NPC, npc);
            chk("wb_csrfd", WB_CSRFD, csrfd);
            chk("wb_rfd", WB_RFD, rfd);
            chk("wb_ecall", 64'(WB_ECALL), 64'(ecall));
        end
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        logic [63:0] addr;
        int r;
        RESET = 1'b1;
        MEM_V = 1'b0;
        MEM_IR = 32'd0;
        MEM_NPC = 64'd0;
        MEM_ALU_RESULT = 64'd0;
        MEM_SR2 = 64'd0;
        MEM_CSRFD = 64'd0;
        MEM_RFD = 64'd0;
        MEM_ECALL = 1'b0;
        DMEM_RDATA = 64'd0;
        DMEM_ACK = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_v", 64'(WB_V), 64'd0);
        chk("rst_wb_result", WB_RESULT, 64'd0);
        chk("rst_wb_ir", 64'(WB_IR), 64'd0);
        chk("rst_wb_misalign", 64'(WB_MISALIGN), 64'd0);
        chk("rst_req", 64'(DMEM_REQ), 64'd0);
        @(negedge clk);
        RESET = 1'b0;

        // LB sign extension, ACK held off so the stall lasts three cycles
        run(1, 7'h03, 3'd0, 64'h1003, 64'd0, 64'h40, 64'h00000000_80000000, 3);
        chk("lb_result_const", WB_RESULT, 64'hFFFFFFFF_FFFFFF80);
        run(0, 7'h13, 3'd0, 64'h0, 64'd0, 64'h44, 64'd0, 1);
        // SH into the top halfword
        run(1, 7'h23, 3'd1, 64'h2006, 64'h1234, 64'h48, 64'd0, 1);
        chk("sh_result_const", WB_RESULT, 64'h2006);
        // Misaligned LW
        run(1, 7'h03, 3'd2, 64'h3002, 64'd0, 64'h4C, rnd64(), 1);
        chk("lw_mis_const", 64'(WB_MISALIGN), 64'd1);
        // ADD then JAL
        run(1, 7'h33, 3'd0, 64'hDEAD_BEEF, 64'd0, 64'h50, 64'd0, 1);
        run(1, 7'h6F, 3'd0, 64'h1234, 64'd0, 64'h100, 64'd0, 1);
        chk("jal_result_const", WB_RESULT, 64'h100);

        // Reset while an LD is outstanding, with ACK in the reset cycle
        @(negedge clk);
        MEM_V = 1'b1;
        MEM_IR = 32'h0000_3003;
        MEM_ALU_RESULT = 64'h8000;
        @(posedge clk);
        @(negedge clk);
        RESET = 1'b1;
        DMEM_ACK = 1'b1;
        DMEM_RDATA = rnd64();
        MEM_V = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wait_wb_v", 64'(WB_V), 64'd0);
        chk("rst_wait_req", 64'(DMEM_REQ), 64'd0);
        chk("rst_wait_stall", 64'(V_MEM_STALL), 64'd0);
        @(negedge clk);
        RESET = 1'b0;
        DMEM_ACK = 1'b1;
        #1;
        chk("stray_ack_req", 64'(DMEM_REQ), 64'd0);
        @(posedge clk);
        #1;
        chk("stray_ack_wb_v", 64'(WB_V), 64'd0);
        DMEM_ACK = 1'b0;

        // Back-to-back LD and SD at minimum latency
        run(1, 7'h03, 3'd3, 64'h9008, 64'd0, 64'h60, rnd64(), 1);
        run(1, 7'h23, 3'd3, 64'h9010, rnd64(), 64'h64, 64'd0, 1);

        for (int t = 0; t < 80; t++) begin
            r = int'($urandom % 8);
            f3 = 3'($urandom % 8);
            if (r <= 2) begin
                opc = 7'h03;
                f3 = 3'($urandom % 7);
            end else if (r <= 4) begin
                opc = 7'h23;
                f3 = 3'($urandom % 4);
            end else if (r == 5) begin
                opc = ($urandom % 2) ? 7'h33 : 7'h13;
            end else if (r == 6) begin
                opc = ($urandom % 2) ? 7'h6F : 7'h67;
            end else begin
                opc = 7'h73;
            end
            addr = rnd64();
            if ($urandom % 2) addr[2:0] = 3'd0;
            run(1'(($urandom % 8) != 0), opc, f3, addr, rnd64(), rnd64(),
                rnd64(), int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
